i2s_tx: RTL and testbench

Parametrised stereo serial-audio transmitter for the synthesiser output path. It sits between the sample engine and the external DAC. It accepts left/right sample pairs over a valid/ready handshake and double-buffers them. It generates the bit clock (`sck`) and word clock (`lrck`) from `clk`, and serialises MSB-first in I2S or left-justified format, with underflow detection.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_bclk_gen.sv | 42 ++++
 rtl/i2s_tx.sv | 137 +++++++++++++
 tb/tb_i2s_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the i2s_tx serial-audio transmitter.
package i2s_pkg;

  // Serial data format selectors (values of the MODE parameter)
  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } mode_t;

  // Default geometry
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_SLOT_W   = 32;
  localparam int DEF_BCLK_DIV = 8;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk by BCLK_DIV into sck and flags the
// cycle on whose closing edge sck falls or rises.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic sck,
  output logic sck_fall,
  output logic sck_rise
);

  localparam int HALF = BCLK_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          sck_q, sck_d;
  logic          term;

  // Half-period counter; sck toggles each time it wraps
  always_comb begin
    term      = (div_cnt_q == CW'(HALF - 1));
    div_cnt_d = term ? '0 : div_cnt_q + 1'b1;
    sck_d     = term ? ~sck_q : sck_q;
  end

  // Divider state, cleared asynchronously so sck restarts low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

  assign sck      = sck_q;
  assign sck_fall = term & sck_q;
  assign sck_rise = term & ~sck_q;

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S / left-justified transmitter with a one-pair holding register.
// Optional macro I2S_TX_UNDERFLOW_CNT_EN adds a saturating underflow counter
// and its underflow_cnt port.
module i2s_tx import i2s_pkg::*; #(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int BCLK_DIV = DEF_BCLK_DIV,
  parameter int MODE     = MODE_I2S
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  output logic                sck,
  output logic                lrck,
  output logic                sdout,
  output logic                underflow
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]         underflow_cnt
`endif
);

  localparam int    FW  = 2 * SLOT_W;
  localparam int    BW  = $clog2(FW);
  localparam mode_t FMT = (MODE == MODE_LJ) ? FMT_LJ : FMT_I2S;

  logic                sck_fall;
  logic                full_q, full_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]       shift_q, shift_d;
  logic                dly_q, dly_d;
  logic                sdout_q, sdout_d;
  logic                lrck_q, lrck_d;
  logic                underflow_q, underflow_d;
  logic                xfer, frame_start, lj_bit;
  logic [FW-1:0]       frame_hold, load_word;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .sck_fall (sck_fall),
    .sck_rise ()
  );

  // Holding register, frame counter and shifter next-state
  always_comb begin
    xfer        = in_valid & ~full_q;
    // bit_cnt_q is the index of the bit about to be driven on this fall
    frame_start = sck_fall & (bit_cnt_q == '0);
    frame_hold  = (FW'(hold_l_q) << (FW - SAMPLE_W)) |
                  (FW'(hold_r_q) << (SLOT_W - SAMPLE_W));
    load_word   = frame_start ? (full_q ? frame_hold : '0) : shift_q;
    lj_bit      = load_word[FW-1];

    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    dly_d       = dly_q;
    sdout_d     = sdout_q;
    lrck_d      = lrck_q;

    // A pair arriving on the load edge itself misses that frame: the load
    // sees the old (empty) state, the capture fills it for the next frame.
    if (xfer) begin
      hold_l_d = in_left;
      hold_r_d = in_right;
    end
    if (xfer)             full_d = 1'b1;
    else if (frame_start) full_d = 1'b0;
    else                  full_d = full_q;

    underflow_d = frame_start & ~full_q;

    if (sck_fall) begin
      bit_cnt_d = (bit_cnt_q == BW'(FW - 1)) ? '0 : bit_cnt_q + 1'b1;
      lrck_d    = (bit_cnt_q >= BW'(SLOT_W));
      shift_d   = load_word << 1;
      dly_d     = lj_bit;
      sdout_d   = (FMT == FMT_LJ) ? lj_bit : dly_q;
    end
  end

  // Datapath state; reset drops any buffered pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q      <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      dly_q       <= 1'b0;
      sdout_q     <= 1'b0;
      lrck_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      dly_q       <= dly_d;
      sdout_q     <= sdout_d;
      lrck_q      <= lrck_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef I2S_TX_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Counts underflowing frame starts, sticking at all-ones
  always_comb begin
    ucnt_d = ucnt_q;
    if (underflow_d && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  // Underflow counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ucnt_q <= '0;
    else      ucnt_q <= ucnt_d;
  end

  assign underflow_cnt = ucnt_q;
`endif

  assign in_ready  = ~full_q;
  assign lrck      = lrck_q;
  assign sdout     = sdout_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Randomised bench for i2s_tx: one LJ and one I2S instance share stimulus;
// a frame-level model predicts sck, lrck, sdout, in_ready and underflow.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int SW = 16, SL = 32, DIV = 4, HALF = DIV / 2;
  localparam int FW = 2 * SL, FRAME = FW * DIV;

  logic          clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [SW-1:0] in_left = '0, in_right = '0;
  logic          rdy_l, sck_l, lrck_l, sd_l, uf_l;
  logic          rdy_i, sck_i, lrck_i, sd_i, uf_i;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  logic [15:0]   cnt_l, cnt_i;
`endif

  always #5 clk = ~clk;

  i2s_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(DIV), .MODE(MODE_LJ)) dut_lj (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l),
    .in_left(in_left), .in_right(in_right), .sck(sck_l), .lrck(lrck_l),
    .sdout(sd_l), .underflow(uf_l)
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    , .underflow_cnt(cnt_l)
`endif
  );

  i2s_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(DIV), .MODE(MODE_I2S)) dut_i2s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_i),
    .in_left(in_left), .in_right(in_right), .sck(sck_i), .lrck(lrck_i),
    .sdout(sd_i), .underflow(uf_i)
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    , .underflow_cnt(cnt_i)
`endif
  );

  int checks = 0, errors = 0;

  // reference model state
  int            n = 0;          // clk edges since reset release
  bit            mfull = 0, exp_uf = 0;
  logic [SW-1:0] hl = '0, hr = '0;
  logic [SW-1:0] fl [0:127];
  logic [SW-1:0] fr [0:127];
  int            mcnt = 0;
  int            ph = 0;
  logic [SW-1:0] seq = 16'h0100;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t n=%0d)", tag, got, exp, $time, n);
    end
  endtask

  // LJ bit j of frame k: {left, pad, right, pad}, MSB first
  function automatic logic lj_bit(input int k, input int j);
    logic [FW-1:0] w;
    w = (FW'(fl[k]) << (FW - SW)) | (FW'(fr[k]) << (SL - SW));
    return w[FW-1-j];
  endfunction

  function automatic logic exp_sd(input bit lj, input int g);
    int k, j;
    k = g / FW;
    j = g % FW;
    if (lj)     return lj_bit(k, j);
    if (j != 0) return lj_bit(k, j - 1);
    return (k == 0) ? 1'b0 : lj_bit(k - 1, FW - 1);
  endfunction

  function automatic bit fs_at(input int e);
    return (e >= DIV) && (((e - DIV) % FRAME) == 0);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sck"},   {sck_l, sck_i},   2'b00);
    chk({tag, "_lrck"},  {lrck_l, lrck_i}, 2'b00);
    chk({tag, "_sdout"}, {sd_l, sd_i},     2'b00);
    chk({tag, "_rdy"},   {rdy_l, rdy_i},   2'b11);
    chk({tag, "_uf"},    {uf_l, uf_i},     2'b00);
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    chk({tag, "_ucnt"},  {cnt_l, cnt_i},   32'd0);
`endif
  endtask

  // one clk cycle: update model at the edge, drive, then check at negedge
  task automatic step();
    bit fs, acc;
    int k, g;
    @(posedge clk);
    acc = 0;
    if (rst) begin
      n++;
      fs     = fs_at(n);
      acc    = in_valid && !mfull;
      exp_uf = fs && !mfull;
      if (fs) begin
        k = (n - DIV) / FRAME;
        if (k < 128) begin
          fl[k] = mfull ? hl : '0;
          fr[k] = mfull ? hr : '0;
        end
        if (!mfull && mcnt < 65535) mcnt++;
      end
      if (acc) begin
        hl = in_left; hr = in_right; mfull = 1;
      end else if (fs) mfull = 0;
    end
    #1;
    if (acc) in_valid = 1'b0;
    case (ph)
      1: if (!in_valid && !mfull) begin
           in_valid = 1'b1; in_left = 16'hA5C3; in_right = 16'h8001; ph = 0;
         end
      2: if (!in_valid) begin
           in_valid = 1'b1; in_left = seq; in_right = ~seq; seq++;
         end
      3: if (!in_valid && $urandom_range(0, 299) == 0) begin
           in_valid = 1'b1; in_left = SW'($urandom); in_right = SW'($urandom);
         end
      4: if (!in_valid && !mfull && fs_at(n + 1)) begin
           in_valid = 1'b1; in_left = SW'($urandom); in_right = SW'($urandom);
         end
      5: if (!in_valid && !mfull) begin
           in_valid = 1'b1; in_left = 16'hBEEF; in_right = 16'hCAFE;
         end
      default: ;
    endcase
    @(negedge clk);
    chk("sck_lj",  sck_l, 64'((n / HALF) % 2));
    chk("sck_i2s", sck_i, 64'((n / HALF) % 2));
    chk("rdy_lj",  rdy_l, 64'(!mfull));
    chk("rdy_i2s", rdy_i, 64'(!mfull));
    chk("uf_lj",   uf_l,  64'(exp_uf));
    chk("uf_i2s",  uf_i,  64'(exp_uf));
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    chk("ucnt_lj",  cnt_l, 64'(mcnt));
    chk("ucnt_i2s", cnt_i, 64'(mcnt));
`endif
    if (n % DIV == HALF) begin
      if (n < DIV) begin
        chk("sd_pre", {sd_l, sd_i, lrck_l, lrck_i}, 4'b0000);
      end else begin
        g = n / DIV - 1;
        chk("sd_lj",  sd_l,   64'(exp_sd(1'b1, g)));
        chk("sd_i2s", sd_i,   64'(exp_sd(1'b0, g)));
        chk("lrck",   {lrck_l, lrck_i}, ((g % FW) >= SL) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic run(input int p, input int cyc);
    ph = p;
    repeat (cyc) step();
  endtask

  function automatic bit at_mid_bit20();
    return mfull && (n >= DIV) && (n % DIV == HALF) && (((n / DIV - 1) % FW) == 20);
  endfunction

  initial begin
    int b;
    rst = 1'b0;
    repeat (5) step();
    check_reset_vals("reset");
    rst = 1'b1;

    run(0, DIV + 2 * FRAME - 8);   // two underflowing frames
    run(1, FRAME);                 // A5C3 / 8001 in frame 2
    run(0, FRAME);
    run(2, 4 * FRAME);             // backpressure, incrementing pairs
    run(3, 8 * FRAME);             // sparse random offers
    run(0, 2 * FRAME);
    run(4, 3 * FRAME);             // offers landing on frame-start edges
    run(0, FRAME);

    // buffer a pair, then reset asynchronously at bit 20 of a frame
    ph = 5;
    b = 0;
    while (!at_mid_bit20() && b < 3 * FRAME) begin
      step();
      b++;
    end
    chk("midrst_reach", 64'(at_mid_bit20()), 64'd1);
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    n = 0; mfull = 0; exp_uf = 0; mcnt = 0; in_valid = 1'b0; ph = 0;
    repeat (3) step();
    rst = 1'b1;
    run(0, 3 * FRAME);             // pair must not reappear
    run(3, 2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
